// File: rtl/imem_program_loader_pkg.sv
// Shared types for the program loader: symbolic opcodes, MIPS field constants,
// the buffered instruction record and word-building helpers.
package imem_program_loader_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [4:0] {
    OP_ADDU, OP_ADDIU, OP_SUBU, OP_SLT, OP_SLTI, OP_SLTU, OP_SLTIU, OP_AND,
    OP_ANDI, OP_OR, OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_SRA, OP_LUI,
    OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_JR, OP_LW, OP_SW
  } asm_op_t;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_SLTI  = 6'h0a;
  localparam logic [5:0] OPC_SLTIU = 6'h0b;
  localparam logic [5:0] OPC_ANDI  = 6'h0c;
  localparam logic [5:0] OPC_LUI   = 6'h0f;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  typedef struct packed {
    asm_op_t     op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [25:0] target;
    logic        last;
  } asm_instr_t;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE, ST_ERROR} state_t;

  function automatic word_t r_word(input logic [4:0] rs, input logic [4:0] rt,
                                   input logic [4:0] rd, input logic [4:0] sh,
                                   input logic [5:0] fn);
    return {OPC_RTYPE, rs, rt, rd, sh, fn};
  endfunction

  function automatic word_t i_word(input logic [5:0] opc, input logic [4:0] rs,
                                   input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  function automatic word_t j_word(input logic [5:0] opc, input logic [25:0] tgt);
    return {opc, tgt};
  endfunction

endpackage

// File: rtl/imem_program_loader_encoder.sv
// Pure combinational encoder: symbolic instruction -> raw 32-bit MIPS word.
// Fields the format does not carry are forced to zero regardless of input.
module imem_program_loader_encoder
  import imem_program_loader_pkg::*;
(
  input  asm_instr_t instr_i,
  output word_t      word_o,
  output logic       reserved_o
);

  always_comb begin
    word_o     = '0;
    reserved_o = 1'b0;
    case (instr_i.op)
      OP_ADDU:  word_o = r_word(instr_i.rs, instr_i.rt, instr_i.rd, 5'd0, FN_ADDU);
      OP_SUBU:  word_o = r_word(instr_i.rs, instr_i.rt, instr_i.rd, 5'd0, FN_SUBU);
      OP_AND:   word_o = r_word(instr_i.rs, instr_i.rt, instr_i.rd, 5'd0, FN_AND);
      OP_OR:    word_o = r_word(instr_i.rs, instr_i.rt, instr_i.rd, 5'd0, FN_OR);
      OP_XOR:   word_o = r_word(instr_i.rs, instr_i.rt, instr_i.rd, 5'd0, FN_XOR);
      OP_NOR:   word_o = r_word(instr_i.rs, instr_i.rt, instr_i.rd, 5'd0, FN_NOR);
      OP_SLT:   word_o = r_word(instr_i.rs, instr_i.rt, instr_i.rd, 5'd0, FN_SLT);
      OP_SLTU:  word_o = r_word(instr_i.rs, instr_i.rt, instr_i.rd, 5'd0, FN_SLTU);
      OP_SLL:   word_o = r_word(5'd0, instr_i.rt, instr_i.rd, instr_i.shamt, FN_SLL);
      OP_SRL:   word_o = r_word(5'd0, instr_i.rt, instr_i.rd, instr_i.shamt, FN_SRL);
      OP_SRA:   word_o = r_word(5'd0, instr_i.rt, instr_i.rd, instr_i.shamt, FN_SRA);
      OP_JR:    word_o = r_word(instr_i.rs, 5'd0, 5'd0, 5'd0, FN_JR);
      OP_ADDIU: word_o = i_word(OPC_ADDIU, instr_i.rs, instr_i.rt, instr_i.imm);
      OP_SLTI:  word_o = i_word(OPC_SLTI, instr_i.rs, instr_i.rt, instr_i.imm);
      OP_SLTIU: word_o = i_word(OPC_SLTIU, instr_i.rs, instr_i.rt, instr_i.imm);
      OP_ANDI:  word_o = i_word(OPC_ANDI, instr_i.rs, instr_i.rt, instr_i.imm);
      OP_LUI:   word_o = i_word(OPC_LUI, 5'd0, instr_i.rt, instr_i.imm);
      OP_BEQ:   word_o = i_word(OPC_BEQ, instr_i.rs, instr_i.rt, instr_i.imm);
      OP_BNE:   word_o = i_word(OPC_BNE, instr_i.rs, instr_i.rt, instr_i.imm);
      OP_LW:    word_o = i_word(OPC_LW, instr_i.rs, instr_i.rt, instr_i.imm);
      OP_SW:    word_o = i_word(OPC_SW, instr_i.rs, instr_i.rt, instr_i.imm);
      OP_J:     word_o = j_word(OPC_J, instr_i.target);
      OP_JAL:   word_o = j_word(OPC_JAL, instr_i.target);
      default:  reserved_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/imem_program_loader.sv
// Streams symbolic instructions through a small FIFO, encodes them and writes
// them to imem from word 0 upward, one word per cycle.
module imem_program_loader
  import imem_program_loader_pkg::*;
#(
  parameter int IMEM_AW    = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  asm_op_t            in_op_i,
  input  logic [4:0]         in_rs_i,
  input  logic [4:0]         in_rt_i,
  input  logic [4:0]         in_rd_i,
  input  logic [4:0]         in_shamt_i,
  input  logic [15:0]        in_imm_i,
  input  logic [25:0]        in_target_i,
  input  logic               in_last_i,
  output logic               imem_we_o,
  output logic [IMEM_AW-1:0] imem_addr_o,
  output word_t              imem_wdata_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               error_o,
  output logic [IMEM_AW:0]   count_o
);

  localparam int PW = $clog2(FIFO_DEPTH);

  state_t             state_q, state_d;
  asm_instr_t         fifo_q [FIFO_DEPTH];
  logic [PW:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic               last_seen_q, last_seen_d;
  logic [IMEM_AW:0]   count_q, count_d;
  logic               we_q, we_d;
  logic [IMEM_AW-1:0] addr_q, addr_d;
  word_t              wdata_q, wdata_d;

  asm_instr_t in_instr, head;
  word_t      enc_word;
  logic       enc_rsv;
  logic       empty, full, push, pop;

  assign in_instr = '{in_op_i, in_rs_i, in_rt_i, in_rd_i, in_shamt_i,
                      in_imm_i, in_target_i, in_last_i};

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                 (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign head  = fifo_q[rd_ptr_q[PW-1:0]];

  // The head is consumed every RUN cycle, so a full FIFO still frees a slot now.
  assign pop        = (state_q == ST_RUN) && !empty;
  assign in_ready_o = (state_q == ST_RUN) && (!full || pop) && !last_seen_q;
  assign push       = in_valid_i && in_ready_o;

  imem_program_loader_encoder u_encoder (
    .instr_i    (head),
    .word_o     (enc_word),
    .reserved_o (enc_rsv)
  );

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q + (PW+1)'(push);
    rd_ptr_d    = rd_ptr_q + (PW+1)'(pop);
    last_seen_d = last_seen_q | (push & in_last_i);
    count_d     = count_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    case (state_q)
      ST_RUN: begin
        if (pop) begin
          if (enc_rsv || count_q[IMEM_AW]) begin
            state_d  = ST_ERROR;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
          end else begin
            we_d    = 1'b1;
            addr_d  = count_q[IMEM_AW-1:0];
            wdata_d = enc_word;
            count_d = count_q + (IMEM_AW+1)'(1);
            if (head.last) state_d = ST_DONE;
          end
        end
      end
      default: begin
        if (start_i) begin
          state_d     = ST_RUN;
          wr_ptr_d    = '0;
          rd_ptr_d    = '0;
          last_seen_d = 1'b0;
          count_d     = '0;
          addr_d      = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q[PW-1:0]] <= in_instr;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      last_seen_q <= 1'b0;
      count_q     <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      last_seen_q <= last_seen_d;
      count_q     <= count_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign busy_o       = (state_q == ST_RUN);
  assign done_o       = (state_q == ST_DONE);
  assign error_o      = (state_q == ST_ERROR);
  assign count_o      = count_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench: per-opcode encoding table plus streaming, error, overflow
// and reset-mid-load sequences on a full-size and a 4-word instance.
module tb_imem_program_loader;
  import imem_program_loader_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic       in_valid0 = 1'b0, in_valid1 = 1'b0;
  asm_instr_t in_instr = '0;

  logic        in_ready0, we0, busy0, done0, error0;
  logic [9:0]  addr0;
  logic [10:0] count0;
  word_t       wdata0;
  logic        in_ready1, we1, busy1, done1, error1;
  logic [1:0]  addr1;
  logic [2:0]  count1;
  word_t       wdata1;

  imem_program_loader #(.IMEM_AW(10), .FIFO_DEPTH(4)) dut0 (
    .clk_i(clk), .reset_i(reset), .start_i(start0), .in_valid_i(in_valid0),
    .in_ready_o(in_ready0), .in_op_i(in_instr.op), .in_rs_i(in_instr.rs),
    .in_rt_i(in_instr.rt), .in_rd_i(in_instr.rd), .in_shamt_i(in_instr.shamt),
    .in_imm_i(in_instr.imm), .in_target_i(in_instr.target), .in_last_i(in_instr.last),
    .imem_we_o(we0), .imem_addr_o(addr0), .imem_wdata_o(wdata0),
    .busy_o(busy0), .done_o(done0), .error_o(error0), .count_o(count0));

  imem_program_loader #(.IMEM_AW(2), .FIFO_DEPTH(4)) dut1 (
    .clk_i(clk), .reset_i(reset), .start_i(start1), .in_valid_i(in_valid1),
    .in_ready_o(in_ready1), .in_op_i(in_instr.op), .in_rs_i(in_instr.rs),
    .in_rt_i(in_instr.rt), .in_rd_i(in_instr.rd), .in_shamt_i(in_instr.shamt),
    .in_imm_i(in_instr.imm), .in_target_i(in_instr.target), .in_last_i(in_instr.last),
    .imem_we_o(we1), .imem_addr_o(addr1), .imem_wdata_o(wdata1),
    .busy_o(busy1), .done_o(done1), .error_o(error1), .count_o(count1));

  typedef struct {
    logic [31:0] addr;
    word_t       data;
    int          cyc;
  } wr_t;

  wr_t wq0[$];
  wr_t wq1[$];
  int  cyc = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (we0) wq0.push_back('{32'(addr0), wdata0, cyc});
    if (we1) wq1.push_back('{32'(addr1), wdata1, cyc});
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic asm_instr_t mk(input asm_op_t op, input logic [4:0] rs,
                                    input logic [4:0] rt, input logic [4:0] rd,
                                    input logic [4:0] sh, input logic [15:0] imm,
                                    input logic [25:0] tg, input logic last);
    return '{op, rs, rt, rd, sh, imm, tg, last};
  endfunction

  task automatic do_start(input int which);
    @(negedge clk);
    if (which == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    wq0.delete();
    wq1.delete();
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input int which, input asm_instr_t b, output int acc);
    int n;
    in_instr = b;
    if (which == 0) in_valid0 = 1'b1; else in_valid1 = 1'b1;
    n = 0;
    while (!((which == 0) ? in_ready0 : in_ready1) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!((which == 0) ? in_ready0 : in_ready1)) begin
      checks++;
      failures++;
      $display("FAIL push_timeout actual=in_ready_low required=in_ready_high");
    end
    @(negedge clk);
    acc = cyc;
  endtask

  task automatic wait_end(input int which);
    int n;
    n = 0;
    while (!((which == 0) ? (done0 | error0) : (done1 | error1)) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!((which == 0) ? (done0 | error0) : (done1 | error1))) begin
      failures++;
      $display("FAIL end_timeout actual=still_busy required=done_or_error");
    end
  endtask

  typedef struct {
    asm_op_t     op;
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] imm;
    logic [25:0] tg;
    word_t       exp;
  } vec_t;

  vec_t vecs[23];

  initial begin
    int acc;
    int acc_q[5];
    string nm;

    vecs[0]  = '{OP_ADDIU,  5'd0, 5'd8, 5'd0, 5'd0, 16'h0005, 26'h0, 32'h24080005};
    vecs[1]  = '{OP_ADDU,   5'd8, 5'd9, 5'd10,5'd0, 16'h0000, 26'h0, 32'h01095021};
    vecs[2]  = '{OP_SLL,    5'd7, 5'd9, 5'd8, 5'd4, 16'h0000, 26'h0, 32'h00094100};
    vecs[3]  = '{OP_J,      5'd3, 5'd0, 5'd0, 5'd0, 16'h0000, 26'h0100000, 32'h08100000};
    vecs[4]  = '{OP_LUI,    5'd5, 5'd1, 5'd0, 5'd0, 16'h1234, 26'h0, 32'h3c011234};
    vecs[5]  = '{OP_SW,     5'd29,5'd8, 5'd0, 5'd0, 16'h0008, 26'h0, 32'hafa80008};
    vecs[6]  = '{OP_SUBU,   5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 26'h0, 32'h00221823};
    vecs[7]  = '{OP_AND,    5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 26'h0, 32'h00221824};
    vecs[8]  = '{OP_OR,     5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 26'h0, 32'h00221825};
    vecs[9]  = '{OP_XOR,    5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 26'h0, 32'h00221826};
    vecs[10] = '{OP_NOR,    5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 26'h0, 32'h00221827};
    vecs[11] = '{OP_SLT,    5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 26'h0, 32'h0022182a};
    vecs[12] = '{OP_SLTU,   5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 26'h0, 32'h0022182b};
    vecs[13] = '{OP_SRL,    5'd1, 5'd2, 5'd3, 5'd5, 16'h0000, 26'h0, 32'h00021942};
    vecs[14] = '{OP_SRA,    5'd1, 5'd2, 5'd3, 5'd5, 16'h0000, 26'h0, 32'h00021943};
    vecs[15] = '{OP_JR,     5'd31,5'd2, 5'd3, 5'd5, 16'h0000, 26'h0, 32'h03e00008};
    vecs[16] = '{OP_SLTI,   5'd1, 5'd2, 5'd3, 5'd0, 16'hfffe, 26'h0, 32'h2822fffe};
    vecs[17] = '{OP_SLTIU,  5'd1, 5'd2, 5'd3, 5'd0, 16'hfffe, 26'h0, 32'h2c22fffe};
    vecs[18] = '{OP_ANDI,   5'd1, 5'd2, 5'd3, 5'd0, 16'hfffe, 26'h0, 32'h3022fffe};
    vecs[19] = '{OP_BEQ,    5'd1, 5'd2, 5'd3, 5'd0, 16'hfffe, 26'h0, 32'h1022fffe};
    vecs[20] = '{OP_BNE,    5'd1, 5'd2, 5'd3, 5'd0, 16'hfffe, 26'h0, 32'h1422fffe};
    vecs[21] = '{OP_LW,     5'd1, 5'd2, 5'd3, 5'd0, 16'hfffe, 26'h0, 32'h8c22fffe};
    vecs[22] = '{OP_JAL,    5'd0, 5'd0, 5'd0, 5'd0, 16'h0000, 26'h3ffffff, 32'h0fffffff};

    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready0, 0);
    chk("rst_we", we0, 0);
    chk("rst_addr", addr0, 0);
    chk("rst_wdata", wdata0, 0);
    chk("rst_flags", {busy0, done0, error0}, 0);
    chk("rst_count", count0, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", in_ready0, 0);

    // One single-word load per opcode.
    for (int i = 0; i < 23; i++) begin
      nm = $sformatf("vec%0d", i);
      do_start(0);
      chk({nm, "_busy"}, busy0, 1);
      push(0, mk(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].sh,
                 vecs[i].imm, vecs[i].tg, 1'b1), acc);
      in_valid0 = 1'b0;
      wait_end(0);
      chk({nm, "_nwr"}, wq0.size(), 1);
      if (wq0.size() > 0) begin
        chk({nm, "_addr"}, wq0[0].addr, 0);
        chk({nm, "_data"}, wq0[0].data, vecs[i].exp);
        chk({nm, "_lat"}, wq0[0].cyc, acc + 1);
      end
      chk({nm, "_done"}, done0, 1);
      chk({nm, "_count"}, count0, 1);
      chk({nm, "_ready"}, in_ready0, 0);
    end

    // Back-to-back stream: consecutive-cycle writes.
    do_start(0);
    push(0, mk(OP_ADDU, 5'd8, 5'd9, 5'd10, 5'd0, 16'h0, 26'h0, 1'b0), acc);
    push(0, mk(OP_SLL, 5'd0, 5'd9, 5'd8, 5'd4, 16'h0, 26'h0, 1'b0), acc);
    push(0, mk(OP_J, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0100000, 1'b1), acc);
    in_valid0 = 1'b0;
    wait_end(0);
    chk("b2b_nwr", wq0.size(), 3);
    if (wq0.size() == 3) begin
      chk("b2b_d0", wq0[0].data, 32'h01095021);
      chk("b2b_d1", wq0[1].data, 32'h00094100);
      chk("b2b_d2", wq0[2].data, 32'h08100000);
      chk("b2b_a", {wq0[0].addr[7:0], wq0[1].addr[7:0], wq0[2].addr[7:0]}, 32'h000102);
      chk("b2b_c1", wq0[1].cyc, wq0[0].cyc + 1);
      chk("b2b_c2", wq0[2].cyc, wq0[0].cyc + 2);
    end
    chk("b2b_count", count0, 3);

    // Gapped input.
    do_start(0);
    push(0, mk(OP_LUI, 5'd0, 5'd1, 5'd0, 5'd0, 16'h1234, 26'h0, 1'b0), acc);
    in_valid0 = 1'b0;
    repeat (3) @(negedge clk);
    push(0, mk(OP_SW, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0008, 26'h0, 1'b1), acc);
    in_valid0 = 1'b0;
    wait_end(0);
    chk("gap_nwr", wq0.size(), 2);
    if (wq0.size() == 2) begin
      chk("gap_d0", wq0[0].data, 32'h3c011234);
      chk("gap_d1", wq0[1].data, 32'hafa80008);
      chk("gap_a1", wq0[1].addr, 1);
    end

    // Reserved op as 3rd of 5 beats.
    do_start(0);
    push(0, mk(OP_ADDIU, 5'd0, 5'd1, 5'd0, 5'd0, 16'h0001, 26'h0, 1'b0), acc);
    push(0, mk(OP_ADDIU, 5'd0, 5'd2, 5'd0, 5'd0, 16'h0002, 26'h0, 1'b0), acc);
    push(0, mk(asm_op_t'(5'd31), 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0), acc);
    in_instr = mk(OP_ADDIU, 5'd0, 5'd3, 5'd0, 5'd0, 16'h0003, 26'h0, 1'b0);
    repeat (4) @(negedge clk);
    chk("err_flag", error0, 1);
    chk("err_busy", busy0, 0);
    chk("err_ready", in_ready0, 0);
    in_valid0 = 1'b0;
    chk("err_nwr", wq0.size(), 2);
    chk("err_count", count0, 2);
    if (wq0.size() > 1) chk("err_d1", wq0[1].data, 32'h24020002);

    // Overflow on the 4-word instance, then restart.
    do_start(1);
    for (int i = 0; i < 5; i++) begin
      push(1, mk(OP_ADDIU, 5'd0, 5'd4, 5'd0, 5'd0, 16'(i), 26'h0, i == 4), acc_q[i]);
    end
    in_valid1 = 1'b0;
    wait_end(1);
    chk("ovf_error", error1, 1);
    chk("ovf_nwr", wq1.size(), 4);
    chk("ovf_count", count1, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < wq1.size()) begin
        chk($sformatf("ovf_a%0d", i), wq1[i].addr, i);
        chk($sformatf("ovf_d%0d", i), wq1[i].data, 32'h24040000 | i);
      end
    end
    do_start(1);
    chk("restart_count", count1, 0);
    chk("restart_error", error1, 0);
    push(1, mk(OP_ADDIU, 5'd0, 5'd5, 5'd0, 5'd0, 16'h0007, 26'h0, 1'b1), acc);
    in_valid1 = 1'b0;
    wait_end(1);
    chk("restart_nwr", wq1.size(), 1);
    if (wq1.size() > 0) begin
      chk("restart_addr", wq1[0].addr, 0);
      chk("restart_data", wq1[0].data, 32'h24050007);
    end
    chk("restart_done", done1, 1);

    // Reset in the middle of a load.
    do_start(0);
    push(0, mk(OP_ADDIU, 5'd0, 5'd1, 5'd0, 5'd0, 16'h0011, 26'h0, 1'b0), acc);
    push(0, mk(OP_ADDIU, 5'd0, 5'd2, 5'd0, 5'd0, 16'h0022, 26'h0, 1'b0), acc);
    reset = 1'b1;
    in_valid0 = 1'b0;
    @(negedge clk);
    chk("mid_rst_we", we0, 0);
    chk("mid_rst_addr", addr0, 0);
    chk("mid_rst_wdata", wdata0, 0);
    chk("mid_rst_flags", {in_ready0, busy0, done0, error0}, 0);
    chk("mid_rst_count", count0, 0);
    reset = 1'b0;
    wq0.delete();
    in_instr = mk(OP_ADDIU, 5'd0, 5'd3, 5'd0, 5'd0, 16'h0033, 26'h0, 1'b1);
    in_valid0 = 1'b1;
    repeat (5) @(negedge clk);
    in_valid0 = 1'b0;
    chk("post_rst_nwr", wq0.size(), 0);
    chk("post_rst_ready", in_ready0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
